alu_share_arbiter: RTL
======================

# alu_share_arbiter

Shares the single combinational 32-bit ALU between NREQ requesters, such as the state-based controller and a second command source. A round-robin grant with valid/ready handshakes admits one operation at a time. The block registers the operands and opcode into the ALU input stage, captures the result and O/C/Z/N flags, and returns them only to the granted requester. It sits between the requesters and the ALU and replaces direct operand-register writes.

## Interface
- NREQ, 2, number of requesters (2..8)
- WIDTH, 32, operand/result width
- RSP_TIMEOUT, 255, cycles a response may wait unclaimed (used only with ALU_ARB_TIMEOUT_EN)

- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NREQ  request present, one bit per requester
- req_ready  out  NREQ  request accepted this cycle
- req_a, req_b  in  NREQ×WIDTH  operands per requester
- req_op  in  NREQ×3  ALU opcode per requester
- rsp_valid  out  NREQ  result available for that requester
- rsp_ready  in  NREQ  requester takes result
- rsp_y  out  WIDTH  result, shared bus, meaningful where rsp_valid set
- rsp_flags  out  4  {O,C,Z,N} captured with rsp_y
- alu_a, alu_b  out  WIDTH  registered ALU operands
- alu_op  out  3  registered ALU opcode
- alu_y  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_o, alu_c, alu_z, alu_n  in  1  ALU flags
- rsp_timeout  out  1  one-cycle pulse when a response is dropped (ALU_ARB_TIMEOUT_EN only, else tied 0)

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: the round-robin arbiter picks the first asserted req_valid at or after pointer rr_ptr.
  - req_ready is asserted combinationally for the winner only.
  - On that edge the block latches req_a/req_b/req_op into alu_a/alu_b/alu_op, stores the grant index, and goes to EXEC.
  - No valid request: stay in IDLE, all req_ready low.
- EXEC: the ALU settles on the held operands. At the end of the cycle the block captures alu_y into rsp_y and {alu_o,alu_c,alu_z,alu_n} into rsp_flags, then goes to RESP.
- RESP: rsp_valid[grant] is held high, and rsp_y/rsp_flags are held stable.
  - When rsp_ready[grant] is high, go to IDLE and set rr_ptr = (grant+1) mod NREQ.
  - rsp_ready of other requesters is ignored.
- Requesters must not make req_valid depend on req_ready. Once asserted, req_valid and its payload are held until accepted.
- alu_a/alu_b/alu_op keep their last values outside EXEC.
- Reset, including mid-operation:
  - state IDLE, rr_ptr 0, grant 0.
  - alu_a/alu_b/alu_op 0, rsp_y 0, rsp_flags 0.
  - all req_ready/rsp_valid 0, rsp_timeout 0.
  - Any in-flight operation is discarded.

## Timing
- Accept edge to rsp_valid high: 2 cycles (EXEC, then RESP asserted).
- Minimum issue interval per operation: 3 cycles (IDLE accept, EXEC, RESP with immediate rsp_ready).
- req_ready depends combinationally on req_valid and state. All other outputs are registered.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 operations.
- A requester may assert a new req_valid while its own rsp_valid is high. The new request is not accepted before the block returns to IDLE.

## Configuration
- ALU_ARB_TIMEOUT_EN defined:
  - An 8-bit counter runs in RESP.
  - If RSP_TIMEOUT cycles elapse without rsp_ready[grant], the block drops the response, pulses rsp_timeout for one cycle, advances rr_ptr, and returns to IDLE.
- Undefined: RESP waits indefinitely, and rsp_timeout is constant 0.

## Structure
- Package alu_arb_pkg holds:
  - state enum (IDLE/EXEC/RESP)
  - alu_op_t (3-bit)
  - alu_flags_t packed struct {O,C,Z,N}
  - default WIDTH constant
- Sub-module rr_arbiter (NREQ-bit request vector and pointer in, one-hot grant and index out) holds the combinational rotate-priority logic.

## Test plan
- Single request: NREQ=2, requester 0 sends a=32'h0000_0005, b=32'h0000_0003, op=3'd0, bench ALU model y=a+b.
  - req_ready[0] is high on the accept cycle.
  - rsp_valid[0] goes high 2 cycles later with rsp_y=8 and flags 4'b0000.
- Simultaneous valid from 0 and 1, held for 4 operations: grant order 0,1,0,1, and rsp_valid is never asserted to a non-granted requester.
- Response back-pressure: hold rsp_ready[1]=0 for 10 cycles.
  - rsp_valid[1], rsp_y and rsp_flags stay stable.
  - req_ready stays low for requester 0 despite its valid.
- Flag capture: bench ALU returns y=0 with Z=1, C=1 for a=32'hFFFF_FFFF, b=1. Required: rsp_flags=4'b0110 and rsp_y=0.
- Reset mid-EXEC: rst_n low for 1 cycle. All outputs are 0 immediately (asynchronous), then IDLE with rr_ptr 0. The first subsequent grant goes to requester 0 when both are valid.
- ALU_ARB_TIMEOUT_EN defined with RSP_TIMEOUT=4: rsp_ready held 0.
  - rsp_timeout pulses once after 4 RESP cycles.
  - rsp_valid drops, and the next pending request is accepted.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU share arbiter: FSM states, opcode and captured flag layout.
package alu_arb_pkg;

  localparam int unsigned ALU_ARB_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef logic [2:0] alu_op_t;

  typedef struct packed {
    logic o;
    logic c;
    logic z;
    logic n;
  } alu_flags_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority picker: first asserted request at or after ptr_i wins; purely combinational.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && req_i[(int'(ptr_i) + i) % int'(NREQ)]) begin
        gnt_o[(int'(ptr_i) + i) % int'(NREQ)] = 1'b1;
        idx_o = IW'((int'(ptr_i) + i) % int'(NREQ));
        found = 1'b1;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU; accept->rsp_valid is 2 cycles, one op in flight.
// Response is held until the granted requester takes it (or dropped after RSP_TIMEOUT with ALU_ARB_TIMEOUT_EN).
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned WIDTH       = ALU_ARB_WIDTH,
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0] req_a,
  input  logic [NREQ-1:0][WIDTH-1:0] req_b,
  input  alu_op_t [NREQ-1:0]         req_op,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [WIDTH-1:0]           rsp_y,
  output alu_flags_t                 rsp_flags,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output alu_op_t                    alu_op,
  input  logic [WIDTH-1:0]           alu_y,
  input  logic                       alu_o,
  input  logic                       alu_c,
  input  logic                       alu_z,
  input  logic                       alu_n,
  output logic                       rsp_timeout
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("alu_share_arbiter: NREQ must be 2..8");
  end
  if (RSP_TIMEOUT < 1 || RSP_TIMEOUT > 256) begin : g_bad_tmo
    $error("alu_share_arbiter: RSP_TIMEOUT must fit the 8-bit response counter");
  end

  arb_state_e       state_q;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d, grant_q;
  logic [NREQ-1:0]  rsp_valid_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, rsp_y_q;
  alu_op_t          alu_op_q;
  alu_flags_t       rsp_flags_q;

  logic [NREQ-1:0]  win_gnt;
  logic [IW-1:0]    win_idx;
  logic             win_any;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Gated by rst_n so every output reads 0 while reset is held.
  assign req_ready = (rst_n && state_q == IDLE) ? win_gnt : '0;
  assign rr_ptr_d  = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef ALU_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       rsp_timeout_q;
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ALU_ARB_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (win_any) begin
            alu_a_q  <= req_a[win_idx];
            alu_b_q  <= req_b[win_idx];
            alu_op_q <= req_op[win_idx];
            grant_q  <= win_idx;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_y_q     <= alu_y;
          rsp_flags_q <= {alu_o, alu_c, alu_z, alu_n};
          rsp_valid_q <= NREQ'(1) << grant_q;
          state_q     <= RESP;
`ifdef ALU_ARB_TIMEOUT_EN
          tmo_cnt_q   <= '0;
`endif
        end
        RESP: begin
          // Only the granted requester's rsp_ready can retire the response.
          if (rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= IDLE;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == 8'(RSP_TIMEOUT - 1)) begin
            rsp_valid_q   <= '0;
            rr_ptr_q      <= rr_ptr_d;
            rsp_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_flags = rsp_flags_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;

endmodule
